adder_result_accumulator: RTL
=============================

# adder_result_accumulator

Downstream consumer of the 8-bit adder stage (ripple-carry or carry-lookahead). Accepts one 9-bit sum per valid/ready handshake and accumulates a fixed batch of samples into a wide running total while tracking the largest sum seen. At the end of each batch it presents total, count, max and a sticky overflow flag on an output handshake. Used to batch-check adder results in the CLA-vs-CRA comparison flow.

## Interface
- SUM_W, 9, width of incoming adder sum (8-bit operands plus carry-out)
- ACC_W, 16, width of running total; must be ≥ SUM_W
- NSAMPLES, 5, samples per batch; 1..255
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inValid  in  1  sum is valid this cycle
- inReady  out  1  block can accept a sum this cycle
- sum  in  SUM_W  adder result (A + B + cIn)
- clear  in  1  synchronous batch abort/restart
- outValid  out  1  batch result available
- outReady  in  1  downstream takes batch result
- total  out  ACC_W  running/final total, modulo 2^ACC_W
- count  out  8  samples accepted in current batch
- maxSum  out  SUM_W  largest sum accepted in current batch
- overflow  out  1  sticky: total wrapped at least once this batch

## Operation
- FSM states: ACCUM, HOLD.
- ACCUM: inReady=1, outValid=0. On accept (inValid & inReady): total ← total + zero-extended sum (truncated to ACC_W); overflow ← overflow | carry out of ACC_W; count ← count+1; maxSum ← max(maxSum, sum). If count+1 == NSAMPLES, next state HOLD.
- HOLD: inReady=0, outValid=1; total/count/maxSum/overflow stable. inValid ignored. On outReady=1: next state ACCUM with total, count, maxSum, overflow all cleared to 0.
- clear=1 (either state): next state ACCUM, all accumulators 0; a handshake in the same cycle is discarded (not counted); an outReady in the same cycle has no additional effect.
- Priority: rst_n > clear > handshake.
- Reset (asynchronous, any time incl. mid-batch): state ACCUM, total 0, count 0, maxSum 0, overflow 0, outValid 0. inReady forced 0 while rst_n low; 1 from first cycle after release.
- Sum of 0 is a valid sample: counted, no change to total.

## Timing
- Accept at edge k → total/count/maxSum/overflow updated visible after edge k (1-cycle latency).
- Final accept at edge k → outValid=1 from after edge k; inReady=0 same time.
- outReady sampled while outValid=1 at edge m → outValid=0, inReady=1, outputs zero after edge m; new sample accepted earliest at edge m+1.
- Full throughput: one sample/cycle in ACCUM; batch of N occupies ≥ N+1 cycles including the output handshake.
- outValid/total/count/maxSum/overflow registered; inReady decoded from state register only (no input-to-output combinational path).

## Structure
- Shared package adder_pkg: state enum (ACCUM, HOLD), SUM_W default constant, operand width constant (8).
- Sub-module sum_max_tracker: registered max of accepted samples with clear input; everything else in the top module.

## Test plan
- Reset, feed sums 377, 136, 13, 230, 123 back-to-back, outReady=0 → outValid after 5th edge; total=879, count=5, maxSum=377, overflow=0; inReady=0 held until outReady.
- Same batch with inValid held 1 in HOLD for 4 cycles, then outReady=1 → no extra accepts, count stays 5; next cycle all outputs 0, inReady=1.
- ACC_W=10, NSAMPLES=3, sums 511, 511, 511 → total=509 (1533 mod 1024), overflow=1, maxSum=511.
- Accept 377, 136; assert clear in same cycle as sum 13 handshake → total=0, count=0; then 5 more samples produce a full fresh batch.
- Accept 2 samples, drop rst_n asynchronously mid-cycle → all outputs 0 immediately, inReady=0 during reset, 1 after release.
- inValid toggling every other cycle with sums 0, 0, 0, 0, 0 → outValid after 5 accepts (9 cycles), total=0, count=5, maxSum=0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder stage and its downstream result consumers.
package adder_pkg;

  localparam int unsigned OPERAND_W     = 8;
  localparam int unsigned SUM_W_DEFAULT = OPERAND_W + 1;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  typedef enum logic [0:0] {
    ACCUM = ST_ACCUM,
    HOLD  = ST_HOLD
  } state_t;

endpackage

// File: rtl/adder_result_accumulator_if.sv
// Sample-in / batch-out handshake bundle for adder_result_accumulator.
interface adder_result_accumulator_if
  import adder_pkg::*;
#(
  parameter int unsigned SUM_W = SUM_W_DEFAULT,
  parameter int unsigned ACC_W = 16
);

  logic             inValid;
  logic             inReady;
  logic [SUM_W-1:0] sum;
  logic             clear;
  logic             outValid;
  logic             outReady;
  logic [ACC_W-1:0] total;
  logic [7:0]       count;
  logic [SUM_W-1:0] maxSum;
  logic             overflow;

  modport master (
    output inValid, sum, clear, outReady,
    input  inReady, outValid, total, count, maxSum, overflow
  );

  modport slave (
    input  inValid, sum, clear, outReady,
    output inReady, outValid, total, count, maxSum, overflow
  );

endinterface

// File: rtl/adder_result_accumulator_sum_max_tracker.sv
// Registered running maximum of accepted samples; clr takes priority over en.
module sum_max_tracker #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] sample,
  output logic [W-1:0] max_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
    end else if (clr) begin
      max_q <= '0;
    end else if (en && (sample > max_q)) begin
      max_q <= sample;
    end
  end

endmodule

// File: rtl/adder_result_accumulator.sv
// Batches adder sums into a wide total with count, max and sticky wrap flag.
module adder_result_accumulator
  import adder_pkg::*;
#(
  parameter int unsigned SUM_W    = SUM_W_DEFAULT,
  parameter int unsigned ACC_W    = 16,
  parameter int unsigned NSAMPLES = 5
) (
  input logic                        clk,
  input logic                        rst_n,
  adder_result_accumulator_if.slave  bus
);

  localparam logic [7:0] LAST_COUNT = 8'(NSAMPLES);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] total_q;
  logic [7:0]       count_q;
  logic             overflow_q;
  logic [SUM_W-1:0] max_q;

  logic             accept;
  logic             restart;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W:0]   add_res;
  logic [7:0]       count_inc;

  // Ready is gated by rst_n so nothing is offered while the block is held in reset.
  assign bus.inReady = rst_n && (state_q == ACCUM);
  assign accept      = bus.inValid && bus.inReady;
  assign restart     = bus.clear || ((state_q == HOLD) && bus.outReady);

  assign sum_ext   = {{(ACC_W + 1 - SUM_W){1'b0}}, bus.sum};
  assign add_res   = {1'b0, total_q} + sum_ext;
  assign count_inc = count_q + 8'd1;

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = ACCUM;
    end else if (accept && (count_inc == LAST_COUNT)) begin
      state_d = HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      total_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (restart) begin
        total_q    <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else if (accept) begin
        total_q    <= add_res[ACC_W-1:0];
        count_q    <= count_inc;
        overflow_q <= overflow_q | add_res[ACC_W];
      end
    end
  end

  sum_max_tracker #(
    .W (SUM_W)
  ) u_max (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (restart),
    .en     (accept),
    .sample (bus.sum),
    .max_q  (max_q)
  );

  assign bus.outValid = (state_q == HOLD);
  assign bus.total    = total_q;
  assign bus.count    = count_q;
  assign bus.maxSum   = max_q;
  assign bus.overflow = overflow_q;

endmodule
